bus_access_ctrl: RTL and testbench
==================================

// Module: bus_access_ctrl
// PURPOSE
//  Sequences every CPU load/store onto the shared data bus. Captures the request and decodes the target:
//  addr[8]=0 selects RAM, addr[8]=1 selects a peripheral, addr[4:2] picks it. Drives the target's one-hot
//  WE/RE strobes and waits on peripheral ready. Registers read data and returns a one-cycle ack to the CPU.
// PARAMETERS
//  DATA_W       32  data bus width
//  N_PERIF      6   peripherals: 0 ADC_control, 1 Teclado, 2 siete_segmentos, 3 LEDs, 4 Switches, 5 Timer
//  TIMEOUT_CYC  16  max wait cycles on perif_ready (used only with BUS_TIMEOUT_EN)
// PORTS
//  clk          in   1               single clock, all logic on rising edge
//  rst          in   1               synchronous reset, active-high
//  cpu_req      in   1               access request, held high until cpu_ack
//  cpu_we       in   1               1=store, 0=load
//  cpu_addr     in   32              byte address
//  cpu_wdata    in   DATA_W          store data
//  cpu_ack      out  1               one-cycle completion pulse
//  cpu_rdata    out  DATA_W          load data, valid while cpu_ack=1
//  cpu_err      out  1               with cpu_ack: unmapped peripheral (or timeout)
//  bus_addr     out  32              registered address to all targets
//  bus_wdata    out  DATA_W          registered store data
//  ram_we       out  1               RAM write strobe
//  ram_rdata    in   DATA_W          RAM read data, valid the cycle after addr is presented
//  perif_we     out  N_PERIF         one-hot peripheral write strobe
//  perif_re     out  N_PERIF         one-hot peripheral read strobe
//  perif_ready  in   N_PERIF         peripheral completed its access
//  perif_rdata  in   N_PERIF*DATA_W  flattened read data; slice i = peripheral i
// BEHAVIOUR
//  Reset: state=IDLE. cpu_ack, cpu_err, ram_we, perif_we and perif_re are 0. cpu_rdata, bus_addr and bus_wdata are 0.
//  FSM: IDLE, RAM_ACC, PERIF_ACC, RESP.
//  IDLE: when cpu_req=1, latch addr/we/wdata into bus_*.
//   - addr[8]=0: go to RAM_ACC.
//   - addr[8]=1 and sel<N_PERIF: go to PERIF_ACC.
//   - addr[8]=1 and sel>=N_PERIF: go straight to RESP with err=1 and rdata=0; no strobe is issued.
//  RAM_ACC: ram_we=we for exactly 1 cycle. Capture ram_rdata into cpu_rdata on loads. Then RESP.
//   RAM latency = ack 2 cycles after the first cycle cpu_req is seen.
//  PERIF_ACC: perif_we[sel]=we or perif_re[sel]=~we, held every cycle until perif_ready[sel]=1.
//   - On that cycle: capture the slice sel on loads, drop the strobes next edge, go to RESP.
//   - Ready from a non-selected peripheral is ignored.
//   - Ready already high on entry gives 1 strobe cycle (ack after 2 cycles).
//  RESP: cpu_ack=1 (plus cpu_err when flagged) for 1 cycle, then IDLE. cpu_rdata holds until the next load completes.
//  cpu_req is sampled only in IDLE; it is don't-care in RAM_ACC and PERIF_ACC. If req drops mid-access the
//   transaction still completes and acks.
//  No back-to-back overlap: a new request is accepted at the earliest in IDLE, the cycle after RESP.
//  At most one strobe bit (ram_we, perif_we, perif_re) is high in any cycle. Stores never return data.
//  rst mid-access: strobes are 0 from the next edge, state=IDLE, and no ack is issued for the aborted access.
// CONFIGURATION
//  BUS_TIMEOUT_EN defined:
//   - An 8-bit wait counter clears on entry to PERIF_ACC.
//   - If TIMEOUT_CYC cycles pass without ready: strobes drop, go to RESP with cpu_err=1 and cpu_rdata=0.
//   - Ready on the same cycle the count expires wins (normal completion, err=0).
//  BUS_TIMEOUT_EN undefined: no counter. PERIF_ACC waits indefinitely; cpu_err only flags unmapped selects.
// STRUCTURE
//  Package bus_map_pkg:
//   - state enum.
//   - REGION_BIT=8 and the SEL_LSB=2/SEL_MSB=4 field positions.
//   - Peripheral index constants PERIF_ADC..PERIF_TIMER.
//  Sub-module bus_addr_decode (combinational):
//   - addr -> is_ram, is_perif, sel, sel_valid.
//   - Reused by the read-data mux.
// TESTING
//  1 RAM store: req, we=1, addr=0x000, wdata=0xDEADBEEF -> ram_we high exactly 1 cycle, ack on cycle 2,
//    no perif strobe.
//  2 RAM load: addr=0x004, ram_rdata=0x12345678 -> ack on cycle 2 with cpu_rdata=0x12345678, err=0.
//  3 LEDs store: addr=0x10C, perif_ready[3] raised 3 cycles later -> perif_we=6'b001000 held for 4 cycles,
//    ack follows, err=0.
//  4 Switches load: addr=0x110, slice 4=0x0000_00A5, ready on entry -> perif_re[4] for 1 cycle,
//    rdata=0xA5.
//  5 Unmapped: addr=0x118 -> no strobe, ack after 1 cycle with err=1 and rdata=0; stray perif_ready[0]
//    during access 3 is ignored.
//  6 rst mid-PERIF_ACC -> strobes 0 next edge, no ack.
//    With BUS_TIMEOUT_EN: ready never rises -> ack+err after 16 wait cycles.

Source files
------------

// File: rtl/bus_map_pkg.sv
// =============================================================================
// Module   : bus_map_pkg
// Address map, FSM state type and peripheral indices for the CPU data bus.
// Revision : 1.0
// =============================================================================
`default_nettype none

package bus_map_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RAM_ACC   = 2'd1,
    S_PERIF_ACC = 2'd2,
    S_RESP      = 2'd3
  } bus_state_e;

  // addr[REGION_BIT] splits RAM from peripherals; addr[SEL_MSB:SEL_LSB] picks the peripheral
  localparam int REGION_BIT = 8;
  localparam int SEL_LSB    = 2;
  localparam int SEL_MSB    = 4;
  localparam int SEL_W      = SEL_MSB - SEL_LSB + 1;

  localparam int PERIF_ADC      = 0;
  localparam int PERIF_TECLADO  = 1;
  localparam int PERIF_SIETESEG = 2;
  localparam int PERIF_LEDS     = 3;
  localparam int PERIF_SWITCHES = 4;
  localparam int PERIF_TIMER    = 5;
  localparam int PERIF_COUNT    = PERIF_TIMER + 1;

endpackage

`default_nettype wire

// File: rtl/bus_addr_decode.sv
// =============================================================================
// Module   : bus_addr_decode
// Combinational address decode: RAM/peripheral region, peripheral select, range.
// Revision : 1.0
// =============================================================================
`default_nettype none

module bus_addr_decode
  import bus_map_pkg::*;
#(
  parameter int N_PERIF = PERIF_COUNT
) (
  input  logic [31:0]      addr,
  output logic             is_ram,
  output logic             is_perif,
  output logic [SEL_W-1:0] sel,
  output logic             sel_valid
);

  logic w_unused_addr_bits;

  assign is_ram    = ~addr[REGION_BIT];
  assign is_perif  = addr[REGION_BIT];
  assign sel       = addr[SEL_MSB:SEL_LSB];
  assign sel_valid = is_perif && (int'(sel) < N_PERIF);

  // Everything outside the region bit and select field is ignored by the map
  assign w_unused_addr_bits = ^{addr[31:REGION_BIT+1], addr[REGION_BIT-1:SEL_MSB+1],
                                addr[SEL_LSB-1:0]};

endmodule

`default_nettype wire

// File: rtl/bus_access_ctrl.sv
// =============================================================================
// Module   : bus_access_ctrl
// Sequences each CPU load/store onto the shared RAM/peripheral data bus.
// Optional : BUS_TIMEOUT_EN bounds the wait on perif_ready to TIMEOUT_CYC cycles.
// Revision : 1.0
// =============================================================================
`default_nettype none

module bus_access_ctrl
  import bus_map_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int N_PERIF     = PERIF_COUNT,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [31:0]               cpu_addr,
  input  logic [DATA_W-1:0]         cpu_wdata,
  output logic                      cpu_ack,
  output logic [DATA_W-1:0]         cpu_rdata,
  output logic                      cpu_err,
  output logic [31:0]               bus_addr,
  output logic [DATA_W-1:0]         bus_wdata,
  output logic                      ram_we,
  input  logic [DATA_W-1:0]         ram_rdata,
  output logic [N_PERIF-1:0]        perif_we,
  output logic [N_PERIF-1:0]        perif_re,
  input  logic [N_PERIF-1:0]        perif_ready,
  input  logic [N_PERIF*DATA_W-1:0] perif_rdata
);

  bus_state_e         r_state;
  bus_state_e         w_state_next;
  logic [31:0]        r_bus_addr;
  logic [DATA_W-1:0]  r_bus_wdata;
  logic               r_we;
  logic               r_err;
  logic [DATA_W-1:0]  r_rdata;

  logic               w_req_is_ram;
  logic               w_req_is_perif;
  logic [SEL_W-1:0]   w_req_sel_unused;
  logic               w_req_sel_valid;
  logic               w_req_unmapped;

  logic               w_bus_is_ram_unused;
  logic               w_bus_is_perif_unused;
  logic [SEL_W-1:0]   w_bus_sel;
  logic               w_bus_sel_valid_unused;

  logic [N_PERIF-1:0] w_sel_onehot;
  logic               w_ready_sel;
  logic [DATA_W-1:0]  w_perif_slice;
  logic               w_timeout;

  // Decode of the incoming request, used only while IDLE
  bus_addr_decode #(.N_PERIF(N_PERIF)) u_req_decode (
    .addr      (cpu_addr),
    .is_ram    (w_req_is_ram),
    .is_perif  (w_req_is_perif),
    .sel       (w_req_sel_unused),
    .sel_valid (w_req_sel_valid)
  );

  // Decode of the latched address drives the strobes and read-data mux
  bus_addr_decode #(.N_PERIF(N_PERIF)) u_bus_decode (
    .addr      (r_bus_addr),
    .is_ram    (w_bus_is_ram_unused),
    .is_perif  (w_bus_is_perif_unused),
    .sel       (w_bus_sel),
    .sel_valid (w_bus_sel_valid_unused)
  );

  assign w_req_unmapped = w_req_is_perif & ~w_req_sel_valid;

  for (genvar gi = 0; gi < N_PERIF; gi++) begin : g_sel_onehot
    assign w_sel_onehot[gi] = (w_bus_sel == SEL_W'(gi));
  end

  assign w_ready_sel = |(perif_ready & w_sel_onehot);

  always_comb begin
    w_perif_slice = '0;
    for (int i = 0; i < N_PERIF; i++) begin
      if (w_sel_onehot[i]) begin
        w_perif_slice = perif_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef BUS_TIMEOUT_EN
  logic [7:0] r_wait_cnt;

  // Counts PERIF_ACC cycles; zero whenever the FSM is elsewhere so each access starts fresh
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= 8'd0;
    end else if (r_state != S_PERIF_ACC) begin
      r_wait_cnt <= 8'd0;
    end else begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  // Ready arriving on the final wait cycle still completes normally
  assign w_timeout = (r_state == S_PERIF_ACC) && !w_ready_sel &&
                     (r_wait_cnt == 8'(TIMEOUT_CYC - 1));
`else
  localparam int c_unused_timeout_cyc = TIMEOUT_CYC;
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    ram_we       = 1'b0;
    perif_we     = '0;
    perif_re     = '0;
    cpu_ack      = 1'b0;
    cpu_err      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cpu_req) begin
          if (w_req_is_ram)        w_state_next = S_RAM_ACC;
          else if (w_req_unmapped) w_state_next = S_RESP;
          else                     w_state_next = S_PERIF_ACC;
        end
      end
      S_RAM_ACC: begin
        ram_we       = r_we;
        w_state_next = S_RESP;
      end
      S_PERIF_ACC: begin
        perif_we = r_we ? w_sel_onehot : '0;
        perif_re = r_we ? '0 : w_sel_onehot;
        if (w_ready_sel || w_timeout) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        cpu_ack      = 1'b1;
        cpu_err      = r_err;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cpu_req) begin
            r_bus_addr  <= cpu_addr;
            r_bus_wdata <= cpu_wdata;
            r_we        <= cpu_we;
            r_err       <= w_req_unmapped;
            if (w_req_unmapped) begin
              r_rdata <= '0;
            end
          end
        end
        S_RAM_ACC: begin
          if (!r_we) begin
            r_rdata <= ram_rdata;
          end
        end
        S_PERIF_ACC: begin
          if (w_ready_sel) begin
            if (!r_we) begin
              r_rdata <= w_perif_slice;
            end
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_rdata = r_rdata;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;

endmodule

`default_nettype wire

// File: tb/tb_bus_access_ctrl.sv
// =============================================================================
// Module   : tb_bus_access_ctrl
// Scoreboard bench: directed and random RAM/peripheral/unmapped accesses.
// Revision : 1.0
// =============================================================================
`default_nettype none

module tb_bus_access_ctrl;
  import bus_map_pkg::*;

  localparam int DATA_W      = 32;
  localparam int N_PERIF     = 6;
  localparam int TIMEOUT_CYC = 16;
`ifdef BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int K_RAM   = 0;
  localparam int K_PERIF = 1;
  localparam int K_UNMAP = 2;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      cpu_req = 1'b0;
  logic                      cpu_we = 1'b0;
  logic [31:0]               cpu_addr = '0;
  logic [DATA_W-1:0]         cpu_wdata = '0;
  logic                      cpu_ack;
  logic [DATA_W-1:0]         cpu_rdata;
  logic                      cpu_err;
  logic [31:0]               bus_addr;
  logic [DATA_W-1:0]         bus_wdata;
  logic                      ram_we;
  logic [DATA_W-1:0]         ram_rdata;
  logic [N_PERIF-1:0]        perif_we;
  logic [N_PERIF-1:0]        perif_re;
  logic [N_PERIF-1:0]        perif_ready = '0;
  logic [N_PERIF*DATA_W-1:0] perif_rdata = '0;

  bus_access_ctrl #(.DATA_W(DATA_W), .N_PERIF(N_PERIF), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .perif_we(perif_we), .perif_re(perif_re), .perif_ready(perif_ready),
    .perif_rdata(perif_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Simple 8-word RAM target, combinational read of the presented address
  logic [DATA_W-1:0] ram_mem [8] = '{default: '0};
  always @(posedge clk) if (ram_we) ram_mem[bus_addr[4:2]] <= bus_wdata;
  assign ram_rdata = ram_mem[bus_addr[4:2]];

  typedef struct {
    int                 issue;
    int                 lat;
    logic [DATA_W-1:0]  rdata;
    logic               err;
    int                 ram_cnt;
    logic [N_PERIF-1:0] we_mask;
    logic [N_PERIF-1:0] re_mask;
    int                 strobe_cyc;
    logic [31:0]        addr;
    logic               chk_wdata;
    logic [DATA_W-1:0]  wdata;
  } exp_t;

  exp_t              sb[$];
  logic [DATA_W-1:0] exp_mem [8] = '{default: '0};
  logic [DATA_W-1:0] model_rdata = '0;
  int total = 0;
  int bad   = 0;

  function automatic void check(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: accumulates strobe activity and compares on every ack
  int                 acc_ram, acc_stb;
  logic [N_PERIF-1:0] acc_we, acc_re;
  logic               acc_onehot;
  logic [31:0]        acc_addr;
  logic [DATA_W-1:0]  acc_wdata;
  initial begin
    exp_t e;
    int   nstb;
    acc_ram = 0; acc_stb = 0; acc_we = '0; acc_re = '0; acc_onehot = 1'b1;
    acc_addr = '0; acc_wdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        acc_ram = 0; acc_stb = 0; acc_we = '0; acc_re = '0; acc_onehot = 1'b1;
      end else begin
        nstb = int'(ram_we) + $countones(perif_we) + $countones(perif_re);
        if (nstb > 1) acc_onehot = 1'b0;
        if (nstb > 0) begin
          acc_stb++;
          acc_addr  = bus_addr;
          acc_wdata = bus_wdata;
        end
        if (ram_we) acc_ram++;
        acc_we |= perif_we;
        acc_re |= perif_re;
        if (cpu_ack) begin
          if (sb.size() == 0) begin
            check("unexpected_ack", 1, 0);
          end else begin
            e = sb.pop_front();
            check("ack_latency", cyc - e.issue, e.lat);
            check("cpu_err", cpu_err, e.err);
            check("cpu_rdata", cpu_rdata, e.rdata);
            check("ram_we_cycles", acc_ram, e.ram_cnt);
            check("perif_we_mask", acc_we, e.we_mask);
            check("perif_re_mask", acc_re, e.re_mask);
            check("strobe_cycles", acc_stb, e.strobe_cyc);
            check("strobe_onehot", acc_onehot, 1);
            if (e.strobe_cyc > 0) check("bus_addr", acc_addr, e.addr);
            if (e.chk_wdata) check("bus_wdata", acc_wdata, e.wdata);
          end
          acc_ram = 0; acc_stb = 0; acc_we = '0; acc_re = '0; acc_onehot = 1'b1;
        end
      end
    end
  end

  task automatic pulse_reset();
    rst = 1'b1; cpu_req = 1'b0; perif_ready = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    model_rdata = '0;
  endtask

  // One transaction: compute the expected response from the access rules, then drive it
  task automatic run_txn(input int kind, input bit we, input int tgt, input int d,
                         input bit stray, input bit drop, input logic [DATA_W-1:0] wdata,
                         input logic [DATA_W-1:0] slice_val, input logic [31:0] junk);
    exp_t e;
    int   scnt;
    bit   done;
    logic [N_PERIF-1:0] oh;
    int   n;
    @(posedge clk); #1;
    oh = '0;
    e.rdata = '0; e.err = 1'b0; e.ram_cnt = 0; e.we_mask = '0; e.re_mask = '0;
    e.strobe_cyc = 0; e.chk_wdata = 1'b0; e.wdata = wdata;
    case (kind)
      K_RAM: begin
        e.addr = (32'(tgt) << 2) | (junk & 32'h0000_00E3);
        e.lat = 2;
        if (we) begin
          e.ram_cnt = 1; e.strobe_cyc = 1; e.chk_wdata = 1'b1;
          exp_mem[tgt] = wdata;
        end else begin
          model_rdata = exp_mem[tgt];
        end
      end
      K_PERIF: begin
        e.addr = 32'h100 | (32'(tgt) << 2) | (junk & 32'h0000_00E3);
        oh[tgt] = 1'b1;
        for (int i = 0; i < N_PERIF; i++) perif_rdata[i*DATA_W +: DATA_W] = $urandom;
        perif_rdata[tgt*DATA_W +: DATA_W] = slice_val;
        if (TO_EN && d >= TIMEOUT_CYC) begin
          n = TIMEOUT_CYC; e.err = 1'b1; model_rdata = '0;
        end else begin
          n = d + 1;
          if (!we) model_rdata = slice_val;
        end
        e.lat = n + 1; e.strobe_cyc = n; e.chk_wdata = we;
        if (we) e.we_mask = oh; else e.re_mask = oh;
      end
      default: begin
        e.addr = 32'h100 | (32'(tgt) << 2) | (junk & 32'h0000_00E3);
        e.lat = 1; e.err = 1'b1; model_rdata = '0;
      end
    endcase
    e.rdata = model_rdata;
    e.issue = cyc;
    sb.push_back(e);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = e.addr; cpu_wdata = wdata;
    scnt = 0; done = 1'b0;
    for (int c = 0; c < 80 && !done; c++) begin
      @(posedge clk); #1;
      if (drop) cpu_req = 1'b0;
      perif_ready = stray ? (N_PERIF'($urandom) & ~oh) : '0;
      if (kind == K_PERIF && ((perif_we & oh) != '0 || (perif_re & oh) != '0)) begin
        scnt++;
        if (scnt == d + 1) perif_ready[tgt] = 1'b1;
      end
      if (cpu_ack) begin
        cpu_req = 1'b0;
        perif_ready = '0;
        done = 1'b1;
      end
    end
    if (!done) begin
      check("txn_ack_bound", 0, 1);
      pulse_reset();
    end
  endtask

  initial begin
    int k, kind, acks;
    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_cpu_err", cpu_err, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_perif_we", perif_we, 0);
    check("rst_perif_re", perif_re, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    rst = 1'b0;

    // Directed accesses
    run_txn(K_RAM, 1'b1, 0, 0, 1'b0, 1'b0, 32'hDEADBEEF, '0, '0);
    run_txn(K_RAM, 1'b1, 1, 0, 1'b0, 1'b0, 32'h12345678, '0, '0);
    run_txn(K_RAM, 1'b0, 1, 0, 1'b0, 1'b0, '0, '0, '0);
    run_txn(K_PERIF, 1'b1, PERIF_LEDS, 3, 1'b1, 1'b0, 32'hCAFE0003, '0, '0);
    run_txn(K_PERIF, 1'b0, PERIF_SWITCHES, 0, 1'b0, 1'b0, '0, 32'h0000_00A5, '0);
    run_txn(K_UNMAP, 1'b0, 6, 0, 1'b0, 1'b0, '0, '0, '0);
    run_txn(K_PERIF, 1'b0, PERIF_ADC, 2, 1'b1, 1'b1, '0, 32'h0BAD_F00D, '0);
    run_txn(K_UNMAP, 1'b1, 7, 0, 1'b0, 1'b0, 32'h1, '0, '0);
    run_txn(K_RAM, 1'b0, 0, 0, 1'b0, 1'b1, '0, '0, '0);

`ifdef BUS_TIMEOUT_EN
    run_txn(K_PERIF, 1'b0, PERIF_TIMER, 1000, 1'b0, 1'b0, '0, 32'h5555_AAAA, '0);
    run_txn(K_PERIF, 1'b0, PERIF_TECLADO, TIMEOUT_CYC - 1, 1'b0, 1'b0, '0, 32'h7777, '0);
    run_txn(K_PERIF, 1'b1, PERIF_SIETESEG, TIMEOUT_CYC, 1'b1, 1'b0, 32'h99, '0, '0);
`endif

    // Reset in the middle of a peripheral access that never becomes ready
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10C; cpu_wdata = 32'h0F0F;
    repeat (3) begin @(posedge clk); #1; end
    check("midrst_strobe_active", perif_we, 6'b001000);
    rst = 1'b1; cpu_req = 1'b0;
    @(posedge clk); #1;
    check("midrst_perif_we", perif_we, 0);
    check("midrst_perif_re", perif_re, 0);
    rst = 1'b0;
    model_rdata = '0;
    acks = 0;
    repeat (4) begin @(posedge clk); #1; acks += int'(cpu_ack); end
    check("midrst_no_ack", acks, 0);

    // Random traffic
    for (int t = 0; t < 250; t++) begin
      k = $urandom_range(0, 99);
      kind = (k < 40) ? K_RAM : (k < 85) ? K_PERIF : K_UNMAP;
      run_txn(kind, 1'($urandom),
              (kind == K_RAM) ? $urandom_range(0, 7) :
              (kind == K_PERIF) ? $urandom_range(0, N_PERIF - 1) : $urandom_range(6, 7),
              TO_EN ? $urandom_range(0, TIMEOUT_CYC + 2) : $urandom_range(0, 5),
              ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 2),
              $urandom, $urandom, $urandom);
    end

    for (int w = 0; w < 20 && sb.size() != 0; w++) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
